// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants: default geometry and the
// flash FSM state encoding used by the border generator.
package vga_pkg;

  localparam int DEF_CW       = 16;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_THICK    = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OFF  = 2'd1;
  localparam logic [1:0] ON   = 2'd2;

endpackage

// File: rtl/flash_ctrl.sv
// Frame-synchronous wall flash sequencer: OFF/ON phases of
// FLASH_FRAMES frames, repeated FLASH_CYCLES times per request.
module flash_ctrl
  import vga_pkg::*;
#(
  parameter int FLASH_FRAMES = 15,
  parameter int FLASH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic flash_req,
  output logic vis,
  output logic flashing
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int YW = $clog2(FLASH_CYCLES + 1);
  localparam logic [FW-1:0] FLAST = FW'(FLASH_FRAMES - 1);
  localparam logic [YW-1:0] YLAST = YW'(FLASH_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [YW-1:0] ccnt, ccnt_n;

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    ccnt_n  = ccnt;
    // a request restarts and swallows any same-cycle tick
    if (flash_req) begin
      state_n = OFF;
      fcnt_n  = '0;
      ccnt_n  = '0;
    end else if (frame_tick) begin
      unique case (1'b1)
        (state == OFF): begin
          if (fcnt == FLAST) begin
            state_n = ON;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
        (state == ON): begin
          if (fcnt == FLAST) begin
            fcnt_n = '0;
            if (ccnt == YLAST) begin
              state_n = IDLE;
              ccnt_n  = '0;
            end else begin
              state_n = OFF;
              ccnt_n  = ccnt + 1'b1;
            end
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fcnt     <= '0;
      ccnt     <= '0;
      flashing <= 1'b0;
    end else begin
      state    <= state_n;
      fcnt     <= fcnt_n;
      ccnt     <= ccnt_n;
      flashing <= (state_n != IDLE);
    end
  end

  assign vis = (state != OFF);

endmodule

// File: rtl/border_gen.sv
// Playfield border generator: registered per-side wall hits,
// side masking and flash-gated wall visibility.
module border_gen
  import vga_pkg::*;
#(
  parameter int CW           = DEF_CW,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int THICK        = DEF_THICK,
  parameter int FLASH_FRAMES = 15,
  parameter int FLASH_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] Horizontal,
  input  logic [CW-1:0] Vertical,
  input  logic          frame_tick,
  input  logic [3:0]    side_en,
  input  logic          flash_req,
  output logic          top,
  output logic          bottom,
  output logic          left,
  output logic          right,
  output logic          GreenWall,
  output logic          flashing
);

  if (THICK < 1 || 2 * THICK > H_ACTIVE || 2 * THICK > V_ACTIVE) begin : g_chk
    $error("border_gen: THICK out of range");
  end

  localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA = CW'(V_ACTIVE);
  localparam logic [CW-1:0] TK = CW'(THICK);
  localparam logic [CW-1:0] RL = CW'(H_ACTIVE - THICK);
  localparam logic [CW-1:0] BL = CW'(V_ACTIVE - THICK);

  logic vis;
  logic act;
  logic t_hit, b_hit, l_hit, r_hit;

  flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_CYCLES(FLASH_CYCLES)
  ) u_flash (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .flash_req (flash_req),
    .vis       (vis),
    .flashing  (flashing)
  );

  assign act   = (Horizontal < HA) && (Vertical < VA);
  assign t_hit = act && (Vertical < TK)    && side_en[3];
  assign b_hit = act && (Vertical >= BL)   && side_en[2];
  assign l_hit = act && (Horizontal < TK)  && side_en[1];
  assign r_hit = act && (Horizontal >= RL) && side_en[0];

  // side flags stay live during OFF so collision keeps working
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top       <= 1'b0;
      bottom    <= 1'b0;
      left      <= 1'b0;
      right     <= 1'b0;
      GreenWall <= 1'b0;
    end else begin
      top       <= t_hit;
      bottom    <= b_hit;
      left      <= l_hit;
      right     <= r_hit;
      GreenWall <= (t_hit | b_hit | l_hit | r_hit) & vis;
    end
  end

endmodule

// File: tb/tb_border_gen.sv
// Randomised bench for border_gen against a frame-level
// model of wall regions and the flash sequence.
module tb_border_gen;

  localparam int FF = 2;
  localparam int FC = 2;
  localparam int SEQ = 2 * FF * FC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Horizontal = '0;
  logic [15:0] Vertical = '0;
  logic        frame_tick = 1'b0;
  logic [3:0]  side_en = 4'hF;
  logic        flash_req = 1'b0;
  logic        top, bottom, left, right, GreenWall, flashing;

  int errors = 0;
  int checks = 0;

  // model state: ticks seen since the last request
  bit m_flash = 0;
  int m_k = 0;

  border_gen #(
    .FLASH_FRAMES(FF),
    .FLASH_CYCLES(FC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Horizontal(Horizontal),
    .Vertical  (Vertical),
    .frame_tick(frame_tick),
    .side_en   (side_en),
    .flash_req (flash_req),
    .top       (top),
    .bottom    (bottom),
    .left      (left),
    .right     (right),
    .GreenWall (GreenWall),
    .flashing  (flashing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit m_vis();
    if (!m_flash) return 1'b1;
    return ((m_k / FF) % 2) == 1;
  endfunction

  function automatic logic [3:0] m_sides(int h, int v, logic [3:0] se);
    bit in_a;
    logic [3:0] r;
    in_a = (h < 640) && (v < 480);
    r[3] = in_a && (v < 8) && se[3];
    r[2] = in_a && (v >= 472) && se[2];
    r[1] = in_a && (h < 8) && se[1];
    r[0] = in_a && (h >= 632) && se[0];
    return r;
  endfunction

  task automatic px(input int h, input int v);
    logic [3:0] e;
    Horizontal = 16'(h);
    Vertical   = 16'(v);
    @(posedge clk);
    #1;
    e = m_sides(h, v, side_en);
    chk($sformatf("top(%0d,%0d)", h, v), top, e[3]);
    chk($sformatf("bottom(%0d,%0d)", h, v), bottom, e[2]);
    chk($sformatf("left(%0d,%0d)", h, v), left, e[1]);
    chk($sformatf("right(%0d,%0d)", h, v), right, e[0]);
    chk($sformatf("wall(%0d,%0d)", h, v), GreenWall,
        int'((|e) && m_vis()));
  endtask

  task automatic tick(input bit req);
    frame_tick = 1'b1;
    flash_req  = req;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    flash_req  = 1'b0;
    if (req) begin
      m_flash = 1;
      m_k = 0;
    end else if (m_flash) begin
      m_k++;
      if (m_k == SEQ) m_flash = 0;
    end
    chk("flashing_tick", flashing, m_flash);
  endtask

  task automatic req();
    flash_req = 1'b1;
    @(posedge clk);
    #1;
    flash_req = 1'b0;
    m_flash = 1;
    m_k = 0;
    chk("flashing_req", flashing, m_flash);
  endtask

  task automatic frame_probe();
    px(100, 3);
    px(3, 200);
    px(300, 300);
  endtask

  int hb[8] = '{0, 7, 8, 631, 632, 639, 640, 65535};
  int vb[8] = '{0, 7, 8, 471, 472, 479, 480, 65535};

  initial begin
    #12;
    chk("rst_top", top, 0);
    chk("rst_wall", GreenWall, 0);
    chk("rst_flashing", flashing, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    px(0, 0);
    px(639, 479);
    px(640, 10);
    foreach (hb[i]) foreach (vb[j]) px(hb[i], vb[j]);
    for (int v = 0; v < 482; v += 17)
      for (int h = 0; h < 645; h += 3) px(h, v);

    side_en = 4'b1010;
    px(635, 100);
    px(0, 0);
    px(639, 479);
    px(4, 479);
    side_en = 4'hF;

    req();
    for (int i = 0; i < SEQ; i++) begin
      frame_probe();
      tick(1'b0);
    end
    frame_probe();

    req();
    for (int i = 0; i < 3; i++) begin
      frame_probe();
      tick(1'b0);
    end
    req();
    for (int i = 0; i < SEQ; i++) begin
      frame_probe();
      tick(1'b0);
    end
    frame_probe();

    req();
    tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < SEQ; i++) begin
      frame_probe();
      tick(1'b0);
    end
    frame_probe();

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) req();
      else if (r < 10) tick(1'b0);
      else if (r < 12) tick(1'b1);
      else begin
        if (r < 20) side_en = 4'($urandom);
        if (r < 60)
          px(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
        else if (r < 80)
          px(int'($urandom_range(0, 15)), int'($urandom_range(0, 480)));
        else
          px(int'($urandom_range(620, 645)), int'($urandom_range(465, 485)));
      end
    end
    side_en = 4'hF;

    req();
    tick(1'b0);
    Horizontal = 16'd100;
    Vertical   = 16'd3;
    @(posedge clk);
    #1;
    chk("pre_rst_top", top, 1);
    chk("pre_rst_flashing", flashing, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_top", top, 0);
    chk("async_wall", GreenWall, 0);
    chk("async_flashing", flashing, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_flash = 0;
    m_k = 0;
    px(3, 3);
    chk("post_rst_flashing", flashing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/border_gen.md
Name: border_gen

Overview:
- Parametrised playfield border generator for the VGA pipeline; successor to the fixed 640x480, 8-pixel green wall.
- Takes the pixel counters and classifies each pixel as top, bottom, left or right wall. Outputs are registered and side-maskable.
- Adds a frame-synchronous flash mode for game events such as a hit or game-over. The wall blinks N times, then returns to solid.
- Sits between the VGA sync/counter block and the pixel colour mux. Side flags also feed collision logic.

Parameters:
- CW, 16, width of the coordinate inputs.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- THICK, 8, wall thickness in pixels. Legal range 1..min(H_ACTIVE,V_ACTIVE)/2.
- FLASH_FRAMES, 15, frames per ON or OFF flash phase.
- FLASH_CYCLES, 3, number of OFF+ON pairs per flash request.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- Horizontal  in  CW  current pixel column.
- Vertical  in  CW  current pixel row.
- frame_tick  in  1  one-cycle pulse, once per frame, at start of vertical blank.
- side_en  in  4  per-side enable, {top,bottom,left,right}.
- flash_req  in  1  one-cycle pulse that starts a flash sequence.
- top, bottom, left, right  out  1 each  registered side hit, gated by side_en.
- GreenWall  out  1  registered wall-visible pixel.
- flashing  out  1  high while a flash sequence is in progress.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, frame and cycle counters 0.
- Region decode. Unsigned compares at CW bits.
  - Pixels with Horizontal >= H_ACTIVE or Vertical >= V_ACTIVE are outside the active area; all side flags are 0 there.
  - top: Vertical < THICK.
  - bottom: Vertical >= V_ACTIVE-THICK.
  - left: Horizontal < THICK.
  - right: Horizontal >= H_ACTIVE-THICK.
  - Each side is ANDed with its side_en bit.
  - Corners assert two flags at once.
- Latency: exactly 1 clk from coordinates to top/bottom/left/right/GreenWall. The colour mux delays its own path by 1 to match.
- GreenWall = OR of the four gated flags, ANDed with vis. vis is 1 in IDLE and ON, 0 in OFF. The side flags are never masked by flash, so collision still works during OFF.
- FSM states and transitions:
  - IDLE: on flash_req, go to OFF with frame_cnt=0 and cyc_cnt=0.
  - OFF: on each frame_tick, frame_cnt++. When frame_cnt reaches FLASH_FRAMES-1 on a tick, go to ON and clear frame_cnt.
  - ON: same counting. At the end of the phase, cyc_cnt++. If cyc_cnt was FLASH_CYCLES-1, go to IDLE; otherwise go to OFF.
- flashing = (state != IDLE), registered.
- flash_req while OFF or ON restarts the sequence: go to OFF and clear both counters.
- flash_req and frame_tick in the same cycle: the request wins and the tick is not counted.
- Visibility changes only on frame_tick edges, so there is no mid-frame tearing.
- Counter widths are $clog2(FLASH_FRAMES+1) and $clog2(FLASH_CYCLES+1). No wrap is possible in legal operation.
- Reset mid-sequence aborts to IDLE with the wall solid after release.
- Elaboration check: THICK must be greater than 0 and at most half of each active dimension. Otherwise $error.

Decomposition:
- Shared package vga_pkg holds H_ACTIVE/V_ACTIVE/THICK defaults, CW, and the flash FSM state encoding localparams (IDLE=2'd0, OFF=2'd1, ON=2'd2).
- One sub-module, flash_ctrl. It contains the FSM and the two counters, takes frame_tick/flash_req, and outputs vis/flashing.
- border_gen keeps the region decode and output registers.

Test Plan:
- Reset, then sweep the full frame with defaults and side_en=4'hF.
  - GreenWall is 1 exactly where H<8, H>=632, V<8 or V>=472 within 640x480, 1 cycle after the coordinates.
  - Pixel (0,0) asserts top and left. Pixel (639,479) asserts bottom and right. Pixel (640,10) gives all 0.
- Set side_en=4'b1010: only top and left flags and wall appear.
  - Pixel (635,100) gives right=0 and GreenWall=0.
- Pulse flash_req with FLASH_FRAMES=2 and FLASH_CYCLES=2, then drive frame_ticks.
  - GreenWall follows OFF,OFF,ON,ON,OFF,OFF,ON,ON per frame, then solid.
  - flashing drops on the 8th tick.
  - top at (100,3) stays 1 throughout.
- Issue flash_req again after 3 ticks into a sequence: counters restart and the full 8-tick sequence repeats.
- Drive flash_req and frame_tick in the same cycle: the tick is not counted, and flashing ends 8 ticks after that cycle.
- Assert rst_n low asynchronously mid-OFF (no clk edge): outputs go to 0 immediately.
  - After release, GreenWall is 1 at (3,3) one cycle later and flashing=0.
